// File: rtl/data_mem_pkg.sv
// Shared state type and bus widths for the data memory responder.
package data_mem_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RD_RESP = 2'd2,
      WR_ACK  = 2'd3
   } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Single-port synchronous RAM: write-enabled store, registered read every cycle.
module data_mem_array
   import data_mem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // NOTE: the array has no reset on purpose; contents must survive reset and
   // a reset branch here would prevent mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Request/response front end for a word-addressed data memory.
// Optional range checking of req_addr is enabled with DATA_MEM_ADDR_CHECK_EN.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_err
);

   localparam int AW = $clog2(DEPTH);

   state_t            r_state;
   state_t            w_next;
   logic [AW-1:0]     r_addr;
   logic [AW-1:0]     w_ram_addr;
   logic              w_accept;
   logic              w_we;
   logic              w_addr_err;
   logic              w_err;
   logic [DATA_W-1:0] w_rdata;
   logic [ADDR_W-1:0] w_unused_addr;

   assign w_accept   = (r_state == IDLE) && req_valid;
   assign w_we       = w_accept && req_write && !w_addr_err && !reset;
   // Reads look up the RAM one cycle after acceptance, from the held address.
   assign w_ram_addr = (r_state == RD_WAIT) ? r_addr : req_addr[AW-1:0];
   assign w_unused_addr = req_addr;

`ifdef DATA_MEM_ADDR_CHECK_EN
   logic r_err;

   assign w_addr_err = (int'(req_addr) >= DEPTH);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= w_addr_err;
      end
   end

   assign w_err = r_err;
`else
   assign w_addr_err = 1'b0;
   assign w_err      = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr <= req_addr[AW-1:0];
      end
   end

   always_comb begin
      // NOTE: defaulting every combinational output first prevents latches.
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (req_valid) w_next = req_write ? WR_ACK : RD_WAIT;
         RD_WAIT: w_next = RD_RESP;
         RD_RESP: w_next = IDLE;
         WR_ACK:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_data  = '0;
      resp_err   = 1'b0;
      case (r_state)
         IDLE: req_ready = 1'b1;
         RD_RESP: begin
            resp_valid = 1'b1;
            resp_data  = w_err ? '0 : w_rdata;
            resp_err   = w_err;
         end
         WR_ACK: begin
            resp_valid = 1'b1;
            resp_err   = w_err;
         end
         default: ;
      endcase
   end

   data_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_ram_addr),
      .i_wdata (req_wdata),
      .o_rdata (w_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-indexed behavioural model of the responder.
module tb_data_mem_responder;

   localparam int DEPTH = 256;
`ifdef DATA_MEM_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [15:0] req_addr  = '0;
   logic [15:0] req_wdata = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [15:0] resp_data;
   logic        resp_err;

   int total = 0;
   int bad   = 0;

   // Model state: windows are numbered by the rising edge that opens them.
   int          n         = 0;
   int          ready_win = 0;
   int          rsp_win   = -1;
   bit          seen_reset = 1'b0;
   logic [15:0] mm [DEPTH];
   bit          kn [DEPTH];
   logic [15:0] rsp_data_m;
   bit          rsp_err_m;
   bit          rsp_known_m;
   bit          was_ready;
   int          ma;
   bit          mbad;
   bit          prev_v = 1'b0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err)
   );

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (window %0d)", nm, got, exp, n);
      end
   endtask

   // Behavioural model: accept when ready, schedule one response, block for a fixed time.
   always @(posedge clk) begin
      was_ready = seen_reset && (n >= ready_win);
      n++;
      if (reset) begin
         seen_reset = 1'b1;
         ready_win  = n;
         rsp_win    = -1;
      end else if (was_ready && req_valid) begin
         ma   = int'(req_addr) % DEPTH;
         mbad = ADDR_CHECK && (int'(req_addr) >= DEPTH);
         if (req_write) begin
            if (!mbad) begin
               mm[ma] = req_wdata;
               kn[ma] = 1'b1;
            end
            rsp_win     = n;
            rsp_data_m  = 16'h0000;
            rsp_known_m = 1'b1;
            ready_win   = n + 1;
         end else begin
            rsp_win     = n + 1;
            rsp_data_m  = mbad ? 16'h0000 : mm[ma];
            rsp_known_m = mbad || kn[ma];
            ready_win   = n + 2;
         end
         rsp_err_m = mbad;
      end
   end

   always @(negedge clk) begin
      if (seen_reset) begin
         check("m_ready", req_ready, (n >= ready_win));
         check("m_valid", resp_valid, (rsp_win == n));
         if (rsp_win == n) begin
            if (rsp_known_m) check("m_data", resp_data, rsp_data_m);
            check("m_err", resp_err, rsp_err_m);
         end else begin
            check("m_idle_data", resp_data, 0);
            check("m_idle_err", resp_err, 0);
         end
         check("m_no_consec_valid", prev_v && resp_valid, 0);
         prev_v = resp_valid;
      end
   end

   task automatic issue(input bit w, input logic [15:0] a, input logic [15:0] d, output int acc);
      int t = 0;
      while (!req_ready && t < 8) begin
         @(negedge clk);
         t++;
      end
      check("issue_ready", req_ready, 1);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      acc       = n;
      req_valid = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit exp_err, output int acc);
      issue(1'b1, a, d, acc);
      check("wr_ack_valid", resp_valid, 1);
      check("wr_ack_data", resp_data, 0);
      check("wr_ack_err", resp_err, exp_err);
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic e, output int acc);
      issue(1'b0, a, 16'h0000, acc);
      check("rd_wait_valid", resp_valid, 0);
      @(negedge clk);
      check("rd_resp_valid", resp_valid, 1);
      d = resp_data;
      e = resp_err;
   endtask

   initial begin
      int          acc;
      int          prev;
      logic [15:0] d;
      logic        e;

      // Request presented while in reset must be ignored.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0005;
      req_wdata = 16'h7777;
      repeat (2) @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_valid", resp_valid, 0);
      check("rst_data", resp_data, 0);
      check("rst_err", resp_err, 0);
      reset     = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);

      wr(16'h0005, 16'h1234, 1'b0, acc);
      @(negedge clk);
      check("wr_ack_once", resp_valid, 0);
      rd(16'h0005, d, e, acc);
      check("rd_5_data", d, 16'h1234);
      check("rd_5_err", e, 0);
      @(negedge clk);
      check("rd_once", resp_valid, 0);

      // Busy-ignore: valid held across a read, turned into a write mid-flight.
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 16'h0005;
      @(negedge clk);
      check("busy_ready_0", req_ready, 0);
      req_write = 1'b1;
      req_wdata = 16'hFFFF;
      @(negedge clk);
      check("busy_ready_1", req_ready, 0);
      check("busy_resp_data", resp_data, 16'h1234);
      req_valid = 1'b0;
      rd(16'h0005, d, e, acc);
      check("busy_mem_kept", d, 16'h1234);

      wr(16'h0105, 16'hBEEF, ADDR_CHECK, acc);
      rd(16'h0005, d, e, acc);
`ifdef DATA_MEM_ADDR_CHECK_EN
      check("range_rd5_data", d, 16'h1234);
      check("range_rd5_err", e, 0);
      rd(16'h0105, d, e, acc);
      check("range_rd105_data", d, 0);
      check("range_rd105_err", e, 1);
`else
      check("wrap_rd5_data", d, 16'hBEEF);
      check("wrap_rd5_err", e, 0);
`endif

      // Reset one edge after a read is accepted aborts it silently.
      wr(16'h0020, 16'h5A5A, 1'b0, acc);
      issue(1'b0, 16'h0020, 16'h0000, acc);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", resp_valid, 0);
      check("rst_mid_ready", req_ready, 1);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_after", resp_valid, 0);
      rd(16'h0020, d, e, acc);
      check("rst_mid_mem", d, 16'h5A5A);

      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wr(16'(i), 16'(16'hA000 + i), 1'b0, acc);
         if (i > 0) check("wr_spacing", 32'(acc - prev), 2);
         prev = acc;
      end
      for (int i = 0; i < 4; i++) begin
         rd(16'(i), d, e, acc);
         check("b2b_rd_data", d, 32'(16'hA000 + i));
         if (i > 0) check("rd_spacing", 32'(acc - prev), 3);
         prev = acc;
      end
      @(negedge clk);

      for (int c = 0; c < 1500; c++) begin
         reset     = ($urandom_range(0, 49) == 0);
         req_valid = ($urandom_range(0, 2) != 0);
         req_write = 1'($urandom_range(0, 1));
         req_addr  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
         req_wdata = 16'($urandom);
         @(negedge clk);
      end
      reset     = 1'b0;
      req_valid = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
